// File: rtl/clkrst_ctrl.sv
// PLL bring-up and system reset sequencer: resets the PLL, waits for a stable
// lock, holds system reset for a while, then runs; retries on timeout, fails sticky.
module clkrst_ctrl #(
    parameter int RESET_CYCLES = 16,
    parameter int LOCK_STABLE  = 64,
    parameter int LOCK_TIMEOUT = 4096,
    parameter int RST_HOLD     = 16,
    parameter int MAX_RETRY    = 3
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       pll_lock,
    input  logic       sw_rst_req,
    output logic       pll_resetb,
    output logic       rst,
    output logic       ready,
    output logic       fail,
    output logic [2:0] state,
    output logic [3:0] retry_cnt,
    output logic [7:0] lost_cnt
);
    typedef enum logic [2:0] {
        ST_PLL_RESET = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_HOLD      = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_e;

    localparam int          TW      = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT + 1) : 1;
    localparam logic [15:0] RC_LAST = 16'(RESET_CYCLES - 1);
    localparam logic [15:0] LS_LAST = 16'(LOCK_STABLE - 1);
    localparam logic [15:0] RH_LAST = 16'(RST_HOLD - 1);
    localparam logic [TW-1:0] TO_LAST = TW'(LOCK_TIMEOUT - 1);
    localparam logic [3:0]  MR      = 4'(MAX_RETRY);

    state_e        st, st_nxt;
    logic [1:0]    lock_pipe;
    logic          lock_s;
    logic [15:0]   cnt, cnt_nxt;
    logic [15:0]   stab, stab_nxt;
    logic [TW-1:0] tmo, tmo_nxt;
    logic [3:0]    retry_nxt;
    logic [7:0]    lost_nxt, lost_inc;

    assign lock_s   = lock_pipe[1];
    assign lost_inc = (lost_cnt == 8'hFF) ? lost_cnt : lost_cnt + 8'd1;
    assign state    = st;

    always_comb begin
        st_nxt    = st;
        cnt_nxt   = cnt;
        stab_nxt  = stab;
        tmo_nxt   = tmo;
        retry_nxt = retry_cnt;
        lost_nxt  = lost_cnt;
        case (st)
            ST_PLL_RESET: begin
                if (cnt == RC_LAST) st_nxt = ST_WAIT_LOCK;
                else                cnt_nxt = cnt + 16'd1;
            end
            ST_WAIT_LOCK: begin
                stab_nxt = lock_s ? stab + 16'd1 : '0;
                tmo_nxt  = tmo + 1'b1;
                // A lock that completes on the timeout cycle still counts.
                if (lock_s && stab == LS_LAST) begin
                    st_nxt = ST_HOLD;
                end else if (tmo == TO_LAST) begin
                    if (retry_cnt < MR) begin
                        st_nxt    = ST_PLL_RESET;
                        retry_nxt = retry_cnt + 4'd1;
                    end else begin
                        st_nxt = ST_FAIL;
                    end
                end
            end
            ST_HOLD: begin
                if (!lock_s) begin
                    st_nxt   = ST_PLL_RESET;
                    lost_nxt = lost_inc;
                end else if (sw_rst_req) begin
                    cnt_nxt = '0;
                end else if (cnt == RH_LAST) begin
                    st_nxt    = ST_RUN;
                    retry_nxt = '0;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    st_nxt   = ST_PLL_RESET;
                    lost_nxt = lost_inc;
                end else if (sw_rst_req) begin
                    st_nxt = ST_HOLD;
                end
            end
            ST_FAIL: begin
                if (sw_rst_req) begin
                    st_nxt    = ST_PLL_RESET;
                    retry_nxt = '0;
                end
            end
            default: st_nxt = ST_PLL_RESET;
        endcase
        if (st_nxt != st) begin
            cnt_nxt  = '0;
            stab_nxt = '0;
            tmo_nxt  = '0;
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as state.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            lock_pipe  <= '0;
            st         <= ST_PLL_RESET;
            cnt        <= '0;
            stab       <= '0;
            tmo        <= '0;
            retry_cnt  <= '0;
            lost_cnt   <= '0;
            pll_resetb <= 1'b0;
            rst        <= 1'b1;
            ready      <= 1'b0;
            fail       <= 1'b0;
        end else begin
            lock_pipe  <= {lock_pipe[0], pll_lock};
            st         <= st_nxt;
            cnt        <= cnt_nxt;
            stab       <= stab_nxt;
            tmo        <= tmo_nxt;
            retry_cnt  <= retry_nxt;
            lost_cnt   <= lost_nxt;
            pll_resetb <= !(st_nxt == ST_PLL_RESET || st_nxt == ST_FAIL);
            rst        <= (st_nxt != ST_RUN);
            ready      <= (st_nxt == ST_RUN);
            fail       <= (st_nxt == ST_FAIL);
        end
    end
endmodule

// File: tb/tb_clkrst_ctrl.sv
// Directed bench for clkrst_ctrl: bring-up latency, glitch, retries/FAIL,
// lock loss, software reset, lost counter saturation, async reset.
module tb_clkrst_ctrl;
    logic       clk_in = 1'b0;
    logic       rst_n = 1'b0, pll_lock = 1'b0, sw_rst_req = 1'b0;
    logic       pll_resetb, rst, ready, fail;
    logic [2:0] state;
    logic [3:0] retry_cnt;
    logic [7:0] lost_cnt;

    int vectors = 0, miscompares = 0;
    int lost_exp = 0;

    clkrst_ctrl #(.LOCK_TIMEOUT(200)) dut (
        .clk_in(clk_in), .rst_n(rst_n), .pll_lock(pll_lock), .sw_rst_req(sw_rst_req),
        .pll_resetb(pll_resetb), .rst(rst), .ready(ready), .fail(fail),
        .state(state), .retry_cnt(retry_cnt), .lost_cnt(lost_cnt)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_st(input string tag, input logic [2:0] s, input int budget, output int n);
        n = 0;
        while (state !== s && n < budget) begin tick(); n++; end
        chk(tag, 32'(state), 32'(s));
    endtask

    task automatic wait_rb(input string tag, input logic v, input int budget, output int n);
        n = 0;
        while (pll_resetb !== v && n < budget) begin tick(); n++; end
        chk(tag, 32'(pll_resetb), 32'(v));
    endtask

    task automatic wait_ready(input int budget, output int n);
        n = 0;
        while (ready !== 1'b1 && n < budget) begin tick(); n++; end
    endtask

    task automatic pulse_sw();
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
    endtask

    // Starts right after PLL_RESET entry with lock low; lock rises 100 cycles after pll_resetb.
    task automatic bringup(input string tag);
        int n, t_hold;
        wait_rb({tag, "_rb_rise"}, 1'b1, 100, n);
        chk({tag, "_rb_low_len"}, n, 16);
        repeat (100) tick();
        pll_lock = 1'b1;
        n = 100;
        t_hold = -1;
        while (ready !== 1'b1 && n < 400) begin
            tick();
            n++;
            if (state == 3'd2 && t_hold < 0) t_hold = n;
        end
        chk({tag, "_hold_at"}, t_hold, 166);
        chk({tag, "_ready_at"}, n, 182);
        chk({tag, "_rst"}, 32'(rst), 0);
        chk({tag, "_retry"}, 32'(retry_cnt), 0);
    endtask

    initial begin
        int n;
        #23;
        chk("rst_state", 32'(state), 0);
        chk("rst_resetb", 32'(pll_resetb), 0);
        chk("rst_rst", 32'(rst), 1);
        chk("rst_ready", 32'(ready), 0);
        chk("rst_fail", 32'(fail), 0);
        chk("rst_retry", 32'(retry_cnt), 0);
        chk("rst_lost", 32'(lost_cnt), 0);
        rst_n = 1'b1;
        bringup("boot");

        // software reset in RUN: back to HOLD, PLL untouched
        pulse_sw();
        chk("sw_state", 32'(state), 2);
        chk("sw_resetb", 32'(pll_resetb), 1);
        chk("sw_rst", 32'(rst), 1);
        wait_ready(50, n);
        chk("sw_hold_len", n, 16);

        // lock loss in RUN
        pll_lock = 1'b0;
        n = 0;
        while (!(rst === 1'b1 && pll_resetb === 1'b0) && n < 20) begin tick(); n++; end
        chk("loss_lat", n, 3);
        lost_exp = 1;
        chk("loss_lost", 32'(lost_cnt), 32'(lost_exp));
        chk("loss_state", 32'(state), 0);

        // lock glitch: stable count restarts after the 1-cycle drop
        wait_rb("glitch_rb", 1'b1, 50, n);
        pll_lock = 1'b1;
        repeat (40) tick();
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        wait_st("glitch_hold", 3'd2, 200, n);
        chk("glitch_lat", n, 66);

        // software reset in HOLD restarts the hold count
        repeat (5) tick();
        pulse_sw();
        chk("hold_sw_state", 32'(state), 2);
        wait_ready(50, n);
        chk("hold_restart_len", n, 16);

        // lock loss coincident with software reset: loss wins
        pll_lock = 1'b0;
        tick();
        tick();
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
        chk("coinc_state", 32'(state), 0);
        lost_exp = 2;
        chk("coinc_lost", 32'(lost_cnt), 32'(lost_exp));

        // no lock: four attempts, then sticky FAIL
        for (int r = 0; r < 4; r++) begin
            wait_rb("nl_rb_rise", 1'b1, 50, n);
            chk("nl_retry", 32'(retry_cnt), 32'(r));
            wait_rb("nl_rb_fall", 1'b0, 300, n);
            chk("nl_tmo_len", n, 200);
        end
        chk("fail_state", 32'(state), 4);
        chk("fail_flag", 32'(fail), 1);
        chk("fail_resetb", 32'(pll_resetb), 0);
        chk("fail_retry", 32'(retry_cnt), 3);
        repeat (50) tick();
        chk("fail_sticky", 32'(state), 4);
        pulse_sw();
        chk("fail_exit_state", 32'(state), 0);
        chk("fail_exit_retry", 32'(retry_cnt), 0);
        chk("fail_exit_flag", 32'(fail), 0);

        // lost counter saturation via repeated loss in HOLD
        for (int i = 0; i < 256; i++) begin
            pll_lock = 1'b1;
            wait_st("sat_hold", 3'd2, 200, n);
            pll_lock = 1'b0;
            wait_st("sat_reset", 3'd0, 10, n);
            lost_exp = (lost_exp < 255) ? lost_exp + 1 : 255;
        end
        chk("lost_sat", 32'(lost_cnt), 32'(lost_exp));

        // asynchronous reset while in HOLD
        pll_lock = 1'b1;
        wait_st("ar_hold", 3'd2, 200, n);
        #3 rst_n = 1'b0;
        #1;
        chk("ar_state", 32'(state), 0);
        chk("ar_rst", 32'(rst), 1);
        chk("ar_resetb", 32'(pll_resetb), 0);
        chk("ar_ready", 32'(ready), 0);
        chk("ar_lost", 32'(lost_cnt), 0);
        pll_lock = 1'b0;
        #2 rst_n = 1'b1;
        bringup("rerun");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
